kernel_config_sequencer: RTL and testbench

Owns the runtime configuration of the convolution datapath: 25 signed kernel coefficients, per-channel R/G/B modifiers, the multiply/divide select, and the precomputed kernel sum. Writes from the control side land in a shadow bank through a valid/ready port. A commit request sums the shadow kernel sequentially, then swaps shadow to active only at a frame boundary, so no frame ever mixes two kernels. Sits between the control logic (switches/UART decoder) and the image processor's kernel/modifier inputs.

---
 rtl/image_proc_pkg.sv | 56 +++++
 rtl/kernel_preset_rom.sv | 17 +
 rtl/kernel_config_sequencer.sv | 130 +++++++++++++
 tb/tb_kernel_config_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_proc_pkg.sv
// Shared types, address map, state encoding and preset kernels for the
// convolution configuration path.
package image_proc_pkg;

   localparam int NUM_COEF  = 25;
   localparam int COEF_BITS = 7;
   localparam int MOD_BITS  = 6;
   localparam int SUM_BITS  = 12;

   typedef logic signed [COEF_BITS-1:0] coef_t;
   typedef coef_t [NUM_COEF-1:0] kernel_t;

   localparam logic [4:0] ADDR_MOD_R  = 5'd25;
   localparam logic [4:0] ADDR_MOD_G  = 5'd26;
   localparam logic [4:0] ADDR_MOD_B  = 5'd27;
   localparam logic [4:0] ADDR_DIV    = 5'd28;
   localparam logic [4:0] ADDR_PRESET = 5'd30;
   localparam logic [4:0] ADDR_COMMIT = 5'd31;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SUM,
      ST_PEND,
      ST_COMMIT
   } seq_state_t;

   localparam coef_t C_Z  = 7'sd0;
   localparam coef_t C_P1 = 7'sd1;
   localparam coef_t C_P2 = 7'sd2;
   localparam coef_t C_P4 = 7'sd4;
   localparam coef_t C_P8 = 7'sd8;
   localparam coef_t C_M1 = -7'sd1;

   // All presets are point-symmetric, so element ordering in the packed
   // concatenation matches index order either way.
   localparam kernel_t KERNEL_IDENTITY = {{12{C_Z}}, C_P1, {12{C_Z}}};
   localparam kernel_t KERNEL_BLUR     = {{6{C_Z}}, C_P1, C_P2, C_P1, {2{C_Z}},
                                          C_P2, C_P4, C_P2, {2{C_Z}},
                                          C_P1, C_P2, C_P1, {6{C_Z}}};
   localparam kernel_t KERNEL_LAPLACE  = {{6{C_Z}}, C_M1, C_M1, C_M1, {2{C_Z}},
                                          C_M1, C_P8, C_M1, {2{C_Z}},
                                          C_M1, C_M1, C_M1, {6{C_Z}}};

   localparam logic [MOD_BITS-1:0] MOD_ONE = MOD_BITS'(1);

   function automatic logic signed [SUM_BITS-1:0] sext_coef(input logic [COEF_BITS-1:0] c);
      return {{(SUM_BITS-COEF_BITS){c[COEF_BITS-1]}}, c};
   endfunction

   // A zero modifier would be a divisor of zero in divide mode.
   function automatic logic [MOD_BITS-1:0] guard_mod(input logic [MOD_BITS-1:0] m,
                                                     input logic div);
      return (div && (m == '0)) ? MOD_ONE : m;
   endfunction

endpackage

// File: rtl/kernel_preset_rom.sv
// Combinational table of the built-in kernels, indexed by a 2-bit select.
module kernel_preset_rom
   import image_proc_pkg::*;
(
   input  logic [1:0] sel,
   output kernel_t    kernel
);

   always_comb begin
      case (sel)
         2'd1:    kernel = KERNEL_BLUR;
         2'd2:    kernel = KERNEL_LAPLACE;
         default: kernel = KERNEL_IDENTITY;
      endcase
   end

endmodule

// File: rtl/kernel_config_sequencer.sv
// Shadow/active configuration bank with frame-synchronous commit.
// Define KERNEL_PRESET_EN to enable whole-kernel preset loads at address 30.
module kernel_config_sequencer
   import image_proc_pkg::*;
(
   input  logic                       clk_25_vga,
   input  logic                       rst_n,
   input  logic                       cfg_valid,
   output logic                       cfg_ready,
   input  logic [4:0]                 cfg_addr,
   input  logic [COEF_BITS-1:0]       cfg_data,
   input  logic                       vga_ready,
   input  logic                       vga_end,
   output kernel_t                    curr_kernel,
   output logic [MOD_BITS-1:0]        r_mod,
   output logic [MOD_BITS-1:0]        g_mod,
   output logic [MOD_BITS-1:0]        b_mod,
   output logic                       div_flag,
   output logic signed [SUM_BITS-1:0] kernel_sum,
   output logic                       kernel_zero,
   output logic                       busy,
   output logic                       commit_done
);

   localparam logic [4:0] LAST_IDX = 5'(NUM_COEF - 1);

   seq_state_t                 state, next_state;
   logic [4:0]                 sum_idx;
   logic signed [SUM_BITS-1:0] acc;
   kernel_t                    sh_kernel;
   logic [MOD_BITS-1:0]        sh_r, sh_g, sh_b;
   logic                       sh_div;
   logic                       wr_en;

`ifdef KERNEL_PRESET_EN
   kernel_t preset_kernel;

   kernel_preset_rom u_preset_rom (
      .sel    (cfg_data[1:0]),
      .kernel (preset_kernel)
   );
`endif

   always_ff @(posedge clk_25_vga or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      cfg_ready  = 1'b0;
      case (state)
         ST_IDLE: begin
            cfg_ready = 1'b1;
            if (cfg_valid && (cfg_addr == ADDR_COMMIT)) next_state = ST_SUM;
         end
         ST_SUM:    if (sum_idx == LAST_IDX) next_state = ST_PEND;
         ST_PEND:   if (vga_end && vga_ready) next_state = ST_COMMIT;
         ST_COMMIT: next_state = ST_IDLE;
         default:   next_state = ST_IDLE;
      endcase
   end

   assign busy  = (state != ST_IDLE);
   assign wr_en = cfg_valid && cfg_ready;

   always_ff @(posedge clk_25_vga or negedge rst_n) begin
      if (!rst_n) begin
         sh_kernel <= KERNEL_IDENTITY;
         sh_r      <= MOD_ONE;
         sh_g      <= MOD_ONE;
         sh_b      <= MOD_ONE;
         sh_div    <= 1'b0;
      end else if (wr_en) begin
         if (cfg_addr < ADDR_MOD_R) sh_kernel[cfg_addr] <= cfg_data;
         case (cfg_addr)
            ADDR_MOD_R: sh_r   <= cfg_data[MOD_BITS-1:0];
            ADDR_MOD_G: sh_g   <= cfg_data[MOD_BITS-1:0];
            ADDR_MOD_B: sh_b   <= cfg_data[MOD_BITS-1:0];
            ADDR_DIV:   sh_div <= cfg_data[0];
            ADDR_PRESET: begin
`ifdef KERNEL_PRESET_EN
               sh_kernel <= preset_kernel;
`endif
            end
            default: ;
         endcase
      end
   end

   // One shadow tap per cycle while summing; cleared whenever idle.
   always_ff @(posedge clk_25_vga or negedge rst_n) begin
      if (!rst_n) begin
         sum_idx <= '0;
         acc     <= '0;
      end else if (state == ST_IDLE) begin
         sum_idx <= '0;
         acc     <= '0;
      end else if (state == ST_SUM) begin
         acc     <= acc + sext_coef(sh_kernel[sum_idx]);
         sum_idx <= sum_idx + 5'd1;
      end
   end

   always_ff @(posedge clk_25_vga or negedge rst_n) begin
      if (!rst_n) begin
         curr_kernel <= KERNEL_IDENTITY;
         r_mod       <= MOD_ONE;
         g_mod       <= MOD_ONE;
         b_mod       <= MOD_ONE;
         div_flag    <= 1'b0;
         kernel_sum  <= SUM_BITS'(1);
         kernel_zero <= 1'b0;
         commit_done <= 1'b0;
      end else begin
         commit_done <= 1'b0;
         if (state == ST_COMMIT) begin
            curr_kernel <= sh_kernel;
            r_mod       <= guard_mod(sh_r, sh_div);
            g_mod       <= guard_mod(sh_g, sh_div);
            b_mod       <= guard_mod(sh_b, sh_div);
            div_flag    <= sh_div;
            kernel_sum  <= acc;
            kernel_zero <= (acc == '0);
            commit_done <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_kernel_config_sequencer.sv
// Self-checking bench for kernel_config_sequencer against an array-based model
// of the shadow and active configuration banks.
module tb_kernel_config_sequencer;

   logic                clk_25_vga = 1'b0;
   logic                rst_n = 1'b0;
   logic                cfg_valid = 1'b0;
   logic                cfg_ready;
   logic [4:0]          cfg_addr = '0;
   logic [6:0]          cfg_data = '0;
   logic                vga_ready = 1'b0;
   logic                vga_end = 1'b0;
   logic [24:0][6:0]    curr_kernel;
   logic [5:0]          r_mod, g_mod, b_mod;
   logic                div_flag;
   logic signed [11:0]  kernel_sum;
   logic                kernel_zero;
   logic                busy;
   logic                commit_done;

   int checks = 0;
   int errors = 0;

   int sh_coef[25], act_coef[25];
   int sh_r, sh_g, sh_b, sh_div;
   int act_r, act_g, act_b, act_div, act_sum;

   logic [206:0] obs_vec;
   assign obs_vec = {curr_kernel, r_mod, g_mod, b_mod, div_flag, kernel_sum, kernel_zero};

   kernel_config_sequencer dut (
      .clk_25_vga  (clk_25_vga),
      .rst_n       (rst_n),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_addr    (cfg_addr),
      .cfg_data    (cfg_data),
      .vga_ready   (vga_ready),
      .vga_end     (vga_end),
      .curr_kernel (curr_kernel),
      .r_mod       (r_mod),
      .g_mod       (g_mod),
      .b_mod       (b_mod),
      .div_flag    (div_flag),
      .kernel_sum  (kernel_sum),
      .kernel_zero (kernel_zero),
      .busy        (busy),
      .commit_done (commit_done)
   );

   always #5 clk_25_vga = ~clk_25_vga;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic void model_reset();
      for (int i = 0; i < 25; i++) sh_coef[i] = (i == 12) ? 1 : 0;
      sh_r = 1; sh_g = 1; sh_b = 1; sh_div = 0;
      act_coef = sh_coef;
      act_r = 1; act_g = 1; act_b = 1; act_div = 0; act_sum = 1;
   endfunction

   function automatic void model_preset(input int sel);
      int blur[9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
      for (int i = 0; i < 25; i++) sh_coef[i] = 0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) begin
            if (sel == 1) sh_coef[(r + 1) * 5 + c + 1] = blur[r * 3 + c];
            if (sel == 2) sh_coef[(r + 1) * 5 + c + 1] = (r == 1 && c == 1) ? 8 : -1;
         end
      if (sel == 0 || sel == 3) sh_coef[12] = 1;
   endfunction

   function automatic void model_write(input int addr, input int data);
      if (addr < 25) sh_coef[addr] = (data >= 64) ? data - 128 : data;
      else if (addr == 25) sh_r = data % 64;
      else if (addr == 26) sh_g = data % 64;
      else if (addr == 27) sh_b = data % 64;
      else if (addr == 28) sh_div = data % 2;
`ifdef KERNEL_PRESET_EN
      else if (addr == 30) model_preset(data % 4);
`endif
   endfunction

   function automatic void model_commit();
      act_coef = sh_coef;
      act_sum = 0;
      foreach (sh_coef[i]) act_sum += sh_coef[i];
      act_div = sh_div;
      act_r = (sh_div == 1 && sh_r == 0) ? 1 : sh_r;
      act_g = (sh_div == 1 && sh_g == 0) ? 1 : sh_g;
      act_b = (sh_div == 1 && sh_b == 0) ? 1 : sh_b;
   endfunction

   function automatic logic [206:0] exp_vec();
      logic [174:0] k;
      for (int i = 0; i < 25; i++) k[i * 7 +: 7] = 7'(act_coef[i]);
      return {k, 6'(act_r), 6'(act_g), 6'(act_b), 1'(act_div), 12'(act_sum), (act_sum == 0)};
   endfunction

   task automatic tick();
      @(posedge clk_25_vga);
      #1;
   endtask

   task automatic cfg_write(input int addr, input int data);
      cfg_valid = 1'b1;
      cfg_addr  = 5'(addr);
      cfg_data  = 7'(data);
      tick();
      cfg_valid = 1'b0;
      model_write(addr, data);
   endtask

   // Issues a commit at cycle T and steps cycles T+1..T+limit. Frame ends are
   // driven at the given offsets; p_nr drives vga_end without vga_ready. While
   // busy, random writes are offered and must be ignored by the DUT.
   task automatic run_commit(input int p_a, input int p_b, input int p_nr, input int limit,
                             output int done_at, output int done_cnt,
                             output bit early_change, output bit busy_bad, output bit ready_bad);
      logic [206:0] old;
      old = obs_vec;
      done_at = -1; done_cnt = 0;
      early_change = 1'b0; busy_bad = 1'b0; ready_bad = 1'b0;
      cfg_valid = 1'b1;
      cfg_addr  = 5'd31;
      cfg_data  = 7'($urandom);
      tick();
      for (int k = 1; k <= limit; k++) begin
         if (commit_done) begin
            done_cnt++;
            if (done_at < 0) done_at = k;
         end
         if (done_at < 0 && obs_vec !== old) early_change = 1'b1;
         if (busy !== (done_at < 0)) busy_bad = 1'b1;
         if (cfg_ready !== (done_at >= 0)) ready_bad = 1'b1;
         cfg_valid = (done_at < 0) ? 1'($urandom) : 1'b0;
         cfg_addr  = 5'($urandom_range(0, 31));
         cfg_data  = 7'($urandom);
         vga_end   = (k == p_a || k == p_b || k == p_nr);
         vga_ready = (k == p_nr) ? 1'b0 : (vga_end ? 1'b1 : 1'($urandom));
         tick();
      end
      cfg_valid = 1'b0;
      vga_end   = 1'b0;
      vga_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if (obs_vec !== exp_vec()) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %0h expected %0h", obs_vec, exp_vec());
      end
      checks++;
      if (cfg_ready !== 1'b1 || busy !== 1'b0 || commit_done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_handshake: got ready=%b busy=%b done=%b expected 1 0 0",
                  cfg_ready, busy, commit_done);
      end
   endtask

   task automatic test_all_ones();
      int d, c; bit e, b, r;
      for (int i = 0; i < 25; i++) cfg_write(i, 1);
      run_commit(40, -1, -1, 45, d, c, e, b, r);
      model_commit();
      checks++;
      if (d !== 42 || c !== 1) begin
         errors++;
         $display("[TB] FAIL all_ones_done: got cycle %0d count %0d expected cycle 42 count 1", d, c);
      end
      checks++;
      if (e || b || r) begin
         errors++;
         $display("[TB] FAIL all_ones_flags: got early=%b busy_bad=%b ready_bad=%b expected 0 0 0", e, b, r);
      end
      checks++;
      if (kernel_sum !== 12'sd25 || obs_vec !== exp_vec()) begin
         errors++;
         $display("[TB] FAIL all_ones_outputs: got %0h expected %0h", obs_vec, exp_vec());
      end
   endtask

   task automatic test_frame_ignore();
      int d, c; bit e, b, r;
      cfg_write(12, 64);
      run_commit(10, 60, 45, 66, d, c, e, b, r);
      model_commit();
      checks++;
      if (d !== 62 || c !== 1 || e) begin
         errors++;
         $display("[TB] FAIL frame_ignore_done: got cycle %0d count %0d early %b expected 62 1 0", d, c, e);
      end
      checks++;
      if (obs_vec !== exp_vec()) begin
         errors++;
         $display("[TB] FAIL frame_ignore_outputs: got %0h expected %0h", obs_vec, exp_vec());
      end
   endtask

   task automatic test_div_guard();
      int d, c; bit e, b, r;
      cfg_write(28, 7'h7F);
      cfg_write(25, 7'h45);
      cfg_write(26, 7'h40);
      cfg_write(27, 7'h3F);
      run_commit(26, -1, -1, 30, d, c, e, b, r);
      model_commit();
      checks++;
      if (d !== 28 || b || r) begin
         errors++;
         $display("[TB] FAIL div_guard_done: got cycle %0d busy_bad %b ready_bad %b expected 28 0 0", d, b, r);
      end
      checks++;
      if (g_mod !== 6'd1 || r_mod !== 6'd5 || b_mod !== 6'd63 || div_flag !== 1'b1) begin
         errors++;
         $display("[TB] FAIL div_guard_mods: got r=%0d g=%0d b=%0d div=%b expected 5 1 63 1",
                  r_mod, g_mod, b_mod, div_flag);
      end
      checks++;
      if (obs_vec !== exp_vec()) begin
         errors++;
         $display("[TB] FAIL div_guard_outputs: got %0h expected %0h", obs_vec, exp_vec());
      end
   endtask

   task automatic test_preset();
      int d, c; bit e, b, r;
      cfg_write(30, 2);
      run_commit(30, -1, -1, 34, d, c, e, b, r);
      model_commit();
      checks++;
      if (d !== 32 || c !== 1) begin
         errors++;
         $display("[TB] FAIL preset_done: got cycle %0d count %0d expected 32 1", d, c);
      end
`ifdef KERNEL_PRESET_EN
      checks++;
      if (kernel_sum !== 12'sd0 || kernel_zero !== 1'b1) begin
         errors++;
         $display("[TB] FAIL preset_zero: got sum %0d zero %b expected 0 1", kernel_sum, kernel_zero);
      end
`endif
      checks++;
      if (obs_vec !== exp_vec()) begin
         errors++;
         $display("[TB] FAIL preset_outputs: got %0h expected %0h", obs_vec, exp_vec());
      end
   endtask

   task automatic test_random();
      int d, c, n, p, early; bit e, b, r;
      for (int it = 0; it < 8; it++) begin
         n = $urandom_range(1, 8);
         for (int w = 0; w < n; w++) cfg_write($urandom_range(0, 30), $urandom_range(0, 127));
         early = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 25) : -1;
         p = $urandom_range(26, 50);
         run_commit(early, p, -1, p + 4, d, c, e, b, r);
         model_commit();
         checks++;
         if (d !== p + 2 || c !== 1 || e || b || r) begin
            errors++;
            $display("[TB] FAIL random_timing[%0d]: got cycle %0d count %0d flags %b%b%b expected %0d 1 000",
                     it, d, c, e, b, r, p + 2);
         end
         checks++;
         if (obs_vec !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL random_outputs[%0d]: got %0h expected %0h", it, obs_vec, exp_vec());
         end
      end
   endtask

   task automatic test_reset_pend();
      int d, c, pulses; bit e, b, r;
      cfg_write(28, 0);
      cfg_write(0, 5);
      cfg_write(25, 9);
      run_commit(-1, -1, -1, 30, d, c, e, b, r);
      checks++;
      if (d !== -1 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL pend_wait: got done %0d busy %b expected -1 1", d, busy);
      end
      rst_n = 1'b0;
      model_reset();
      #2;
      checks++;
      if (obs_vec !== exp_vec() || busy !== 1'b0 || commit_done !== 1'b0 || cfg_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_pend_outputs: got %0h busy %b expected %0h busy 0",
                  obs_vec, busy, exp_vec());
      end
      tick();
      rst_n = 1'b1;
      pulses = 0;
      vga_end = 1'b1;
      vga_ready = 1'b1;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (commit_done) pulses++;
      end
      vga_end = 1'b0;
      vga_ready = 1'b0;
      checks++;
      if (pulses !== 0 || obs_vec !== exp_vec()) begin
         errors++;
         $display("[TB] FAIL reset_pend_discard: got %0d pulses out %0h expected 0 pulses out %0h",
                  pulses, obs_vec, exp_vec());
      end
      run_commit(26, -1, -1, 30, d, c, e, b, r);
      model_commit();
      checks++;
      if (d !== 28 || obs_vec !== exp_vec()) begin
         errors++;
         $display("[TB] FAIL reset_shadow: got cycle %0d out %0h expected 28 out %0h", d, obs_vec, exp_vec());
      end
   endtask

   initial begin
      test_reset();
      test_all_ones();
      test_frame_ignore();
      test_div_guard();
      test_preset();
      test_random();
      test_reset_pend();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
